bmat_issue_ctrl: RTL and testbench

- Core-side initiator for the multi-cycle bit-matrix multiply engine (bmator/bmatxor).
- Accepts ops from the execute pipeline over valid/ready.
- Drives the engine's start/xoren/rs1/rs2 interface and captures rd in the single cycle the engine pulses done.
- Returns the tagged result over valid/ready and handles pipeline flush of in-flight ops.

---
 rtl/bmat_pkg.sv | 14 +
 rtl/bmat_rsp_reg.sv | 42 ++++
 rtl/bmat_issue_ctrl.sv | 126 ++++++++++++
 tb/tb_bmat_issue_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bmat_pkg.sv
// Shared types and defaults for the bit-matrix multiply issue controller.
package bmat_pkg;

    localparam int XLEN            = 64;
    localparam int DEF_TAG_W       = 5;
    localparam int DEF_TIMEOUT_CYC = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/bmat_rsp_reg.sv
// Response holding register: captures an engine result and holds it until drained or flushed.
module bmat_rsp_reg #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             capture,
    input  logic [XLEN-1:0]  cap_rd,
    input  logic [TAG_W-1:0] cap_tag,
    input  logic             cap_err,
    input  logic             flush,
    input  logic             rsp_ready,
    output logic             rsp_valid,
    output logic [XLEN-1:0]  rsp_rd,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err
);

    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rd    <= '0;
            rsp_tag   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (capture) begin
                rsp_rd  <= cap_rd;
                rsp_tag <= cap_tag;
                rsp_err <= cap_err;
            end
            // flush beats capture beats drain
            if (flush)
                rsp_valid <= 1'b0;
            else if (capture)
                rsp_valid <= 1'b1;
            else if (rsp_ready)
                rsp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/bmat_issue_ctrl.sv
// Issue controller for the bmator/bmatxor engine: launch, wait for done, return tagged result.
// Optional watchdog enabled with `define BMAT_ISSUE_CTRL_TIMEOUT_EN.
module bmat_issue_ctrl #(
    parameter int XLEN        = bmat_pkg::XLEN,
    parameter int TAG_W       = bmat_pkg::DEF_TAG_W,
    parameter int TIMEOUT_CYC = bmat_pkg::DEF_TIMEOUT_CYC
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_xor,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_rd,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             eng_start,
    output logic             eng_xoren,
    output logic [XLEN-1:0]  eng_rs1,
    output logic [XLEN-1:0]  eng_rs2,
    input  logic [XLEN-1:0]  eng_rd,
    input  logic             eng_busy,
    input  logic             eng_done
);
    import bmat_pkg::*;

    state_t           state, state_nx;
    logic [TAG_W-1:0] tag_q;
    logic             squash;
    logic             accept;
    logic             finish;
    logic             timeout;
    logic             capture;
    logic [XLEN-1:0]  cap_rd;

    // The response slot must be free (or draining) before accepting, so done never finds it full.
    assign req_ready = (state == IDLE) && !flush && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign eng_start = (state == START);
    assign finish    = (state == WAIT) && (eng_done || timeout);
    assign capture   = finish && !squash && !flush;
    assign cap_rd    = eng_done ? eng_rd : '0;

`ifdef BMAT_ISSUE_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wd_cnt;

    always_ff @(posedge clock) begin
        if (reset || state != WAIT)
            wd_cnt <= '0;
        else if (!eng_done)
            wd_cnt <= wd_cnt + 1'b1;
    end

    assign timeout = (state == WAIT) && !eng_done && (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    // Sequencing ignores the engine's busy flag; parameter only matters with the watchdog.
    logic unused_ok;
    assign unused_ok = ^{eng_busy, 32'(TIMEOUT_CYC)};

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = START;
            START:   state_nx = WAIT;
            WAIT:    if (finish) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            eng_xoren <= 1'b0;
            eng_rs1   <= '0;
            eng_rs2   <= '0;
            tag_q     <= '0;
        end else if (accept) begin
            eng_xoren <= req_xor;
            eng_rs1   <= req_rs1;
            eng_rs2   <= req_rs2;
            tag_q     <= req_tag;
        end
    end

    // The engine cannot be aborted: a flushed op still runs to done, its result is dropped.
    always_ff @(posedge clock) begin
        if (reset || finish)
            squash <= 1'b0;
        else if (flush && state != IDLE)
            squash <= 1'b1;
    end

    bmat_rsp_reg #(
        .XLEN  (XLEN),
        .TAG_W (TAG_W)
    ) u_rsp (
        .clock     (clock),
        .reset     (reset),
        .capture   (capture),
        .cap_rd    (cap_rd),
        .cap_tag   (tag_q),
        .cap_err   (timeout),
        .flush     (flush),
        .rsp_ready (rsp_ready),
        .rsp_valid (rsp_valid),
        .rsp_rd    (rsp_rd),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err)
    );

endmodule

// File: tb/tb_bmat_issue_ctrl.sv
// Scoreboard bench for bmat_issue_ctrl with an engine model and a cycle-level reference model.
module tb_bmat_issue_ctrl;
    localparam int XLEN  = 64;
    localparam int TAG_W = 5;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0, req_ready, req_xor = 1'b0;
    logic [XLEN-1:0]  req_rs1 = '0, req_rs2 = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             flush = 1'b0, rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [XLEN-1:0]  rsp_rd;
    logic [TAG_W-1:0] rsp_tag;
    logic             eng_start, eng_xoren, eng_busy = 1'b0, eng_done = 1'b0;
    logic [XLEN-1:0]  eng_rs1, eng_rs2, eng_rd = '0;

    int checks = 0, failures = 0, cyc = 0;

    typedef struct {
        logic [XLEN-1:0]  rd;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;
    exp_t q[$];

    bmat_issue_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W), .TIMEOUT_CYC(16)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_xor(req_xor),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .eng_start(eng_start), .eng_xoren(eng_xoren), .eng_rs1(eng_rs1),
        .eng_rs2(eng_rs2), .eng_rd(eng_rd), .eng_busy(eng_busy), .eng_done(eng_done)
    );

    always #5 clock = ~clock;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", nm, act, exp, cyc);
        end
    endfunction

    // Engine model: done 9 edges after start is sampled; rd meaningful only during done.
    int          e_cnt = 0;
    logic [63:0] e_a = '0, e_b = '0;
    bit          eng_mute = 0;
    always @(negedge clock) begin
        eng_done = 1'b0;
        eng_rd   = {$urandom, $urandom};
        if (e_cnt > 0) begin
            e_cnt--;
            if (e_cnt == 0 && !eng_mute) begin
                eng_done = 1'b1;
                eng_rd   = e_a ^ e_b;
            end
        end
        if (eng_start) begin
            e_cnt = 9;
            e_a   = eng_rs1;
            e_b   = eng_rs2;
        end
        eng_busy = (e_cnt > 0);
    end

    // Reference model: one op in flight, result due 10 cycles after accept, rsp slot of depth one.
    bit               busy = 0, squashed = 0, m_x = 0, m_mute = 0, exp_ready, exp_start;
    int               acc = 0;
    logic [63:0]      m_a = '0, m_b = '0;
    logic [TAG_W-1:0] m_tag = '0;
    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            busy = 0;
            q.delete();
        end else begin
            exp_ready = !busy && !flush && (q.size() == 0 || rsp_ready);
            chk("req_ready", req_ready, exp_ready);
            chk("rsp_valid", rsp_valid, q.size() != 0);
            if (q.size() != 0 && rsp_valid) begin
                chk("rsp_rd", rsp_rd, q[0].rd);
                chk("rsp_tag", rsp_tag, q[0].tag);
                chk("rsp_err", rsp_err, q[0].err);
            end
            exp_start = busy && (cyc == acc + 1);
            chk("eng_start", eng_start, exp_start);
            if (exp_start) begin
                chk("eng_xoren", eng_xoren, m_x);
                chk("eng_rs1", eng_rs1, m_a);
                chk("eng_rs2", eng_rs2, m_b);
            end
            if (q.size() != 0 && rsp_ready) void'(q.pop_front());
            if (flush) q.delete();
            if (busy) begin
                if (flush) squashed = 1;
                if (!m_mute && cyc == acc + 10) begin
                    busy = 0;
                    if (!squashed) q.push_back('{m_a ^ m_b, m_tag, 1'b0});
                end
`ifdef BMAT_ISSUE_CTRL_TIMEOUT_EN
                else if (m_mute && cyc == acc + 18 - 1) begin
                    busy = 0;
                    if (!squashed) q.push_back('{64'h0, m_tag, 1'b1});
                end
`endif
            end else if (req_valid && exp_ready) begin
                busy = 1; acc = cyc; squashed = 0;
                m_x = req_xor; m_a = req_rs1; m_b = req_rs2; m_tag = req_tag; m_mute = eng_mute;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic x, input logic [63:0] a, input logic [63:0] b,
                        input logic [TAG_W-1:0] t, input bit rnd, output int w);
        bit got = 0;
        w = 0;
        req_valid = 1'b1; req_xor = x; req_rs1 = a; req_rs2 = b; req_tag = t;
        while (!got && w < 100) begin
            if (rnd) begin
                rsp_ready = ($urandom_range(0, 3) != 0);
                flush     = ($urandom_range(0, 19) == 0);
            end
            @(negedge clock);
            got = req_ready;
            step();
            if (!got) w++;
        end
        req_valid = 1'b0;
        if (rnd) flush = 1'b0;
        if (!got) chk("send_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        repeat (3) step();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_eng_xoren", eng_xoren, 0);
        chk("rst_eng_rs1", eng_rs1, 0);
        chk("rst_eng_rs2", eng_rs2, 0);
        chk("rst_rsp_rd", rsp_rd, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_rsp_err", rsp_err, 0);
        step();

        // basic xor op
        send(1'b1, 64'hFF00, 64'h00FF, 5'd3, 0, w);
        chk("t1_accept_wait", w, 0);
        repeat (14) step();

        // long backpressure, then drain and accept on the same edge
        rsp_ready = 1'b0;
        send(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 5'd9, 0, w);
        repeat (30) step();
        rsp_ready = 1'b1;
        send(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 5'd10, 0, w);
        chk("t2_same_edge_accept", w, 0);
        repeat (12) step();

        // flush in WAIT, then a clean op
        send(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 5'd4, 0, w);
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (10) step();
        send(1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 5'd7, 0, w);
        repeat (12) step();

        // flush against a held response with a competing request
        rsp_ready = 1'b0;
        send(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 5'd12, 0, w);
        repeat (12) step();
        flush = 1'b1; req_valid = 1'b1;
        @(negedge clock);
        chk("t4_no_accept", req_ready, 0);
        step();
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clock);
        chk("t4_rsp_dropped", rsp_valid, 0);
        step();
        rsp_ready = 1'b1;

        // reset while waiting on the engine
        send(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 5'd2, 0, w);
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_eng_start", eng_start, 0);
        chk("t5_idle_ready", req_ready, 1);
        step();
        repeat (12) step();

        // randomized traffic with backpressure and flushes
        for (int i = 0; i < 40; i++) begin
            send($urandom_range(0, 1), {$urandom, $urandom}, {$urandom, $urandom},
                 TAG_W'($urandom), 1, w);
            repeat ($urandom_range(0, 14)) begin
                rsp_ready = ($urandom_range(0, 3) != 0);
                flush     = ($urandom_range(0, 19) == 0);
                step();
            end
            flush = 1'b0;
        end
        rsp_ready = 1'b1;
        repeat (15) step();

`ifdef BMAT_ISSUE_CTRL_TIMEOUT_EN
        eng_mute = 1;
        send(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 5'd21, 0, w);
        repeat (22) step();
        eng_mute = 0;
        repeat (5) step();
`endif

        rsp_ready = 1'b1;
        flush = 1'b0;
        repeat (15) step();
        chk("sb_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
